sdram_read: RTL and testbench

Read-side command generator for the SDRAM controller, the counterpart of the write path that `wr_trig` starts. On `rd_trig` it asks the top-level arbiter for the bus. Once granted, it opens a row and issues back-to-back burst-4 READ commands, registering returned data from `sdram_dq`. If the arbiter raises `ref_req`, it yields at a burst boundary and resumes afterwards. It sits beside the init, auto-refresh and write blocks inside `sdram_top`; the arbiter muxes its command, address and bank outputs onto the SDRAM pins.

---
 rtl/sdram_read_if.sv | 25 ++
 rtl/sdram_read.sv | 174 +++++++++++++++++
 tb/tb_sdram_read.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_read_if.sv
// Read-path signal bundle between sdram_read and the SDRAM arbiter/pins.
// The read block is the bus requester (master); the arbiter side is the slave.
interface sdram_read_if;
  logic        rd_trig;
  logic        rd_en;
  logic        ref_req;
  logic        rd_req;
  logic        rd_end;
  logic [3:0]  rd_cmd;
  logic [11:0] rd_addr;
  logic [1:0]  rd_bank;
  logic [15:0] sdram_dq;
  logic [15:0] rd_data;
  logic        rd_data_vld;

  modport master (
    input  rd_trig, rd_en, ref_req, sdram_dq,
    output rd_req, rd_end, rd_cmd, rd_addr, rd_bank, rd_data, rd_data_vld
  );

  modport slave (
    output rd_trig, rd_en, ref_req, sdram_dq,
    input  rd_req, rd_end, rd_cmd, rd_addr, rd_bank, rd_data, rd_data_vld
  );
endinterface

// File: rtl/sdram_read.sv
// Read-side SDRAM command generator: requests the bus, opens a row, streams
// back-to-back burst-4 READs and yields to auto-refresh at burst boundaries.
module sdram_read #(
  parameter int CAS_LAT   = 3,
  parameter int TRCD      = 2,
  parameter int TRP       = 2,
  parameter int BURST_NUM = 4
) (
  input  logic         sclk,
  input  logic         s_rst_n,
  sdram_read_if.master bus
);
  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_ACT  = 4'b0011;
  localparam logic [3:0] CMD_READ = 4'b0101;
  localparam logic [3:0] CMD_PRE  = 4'b0010;

  localparam int BW = $clog2(BURST_NUM + 1);
  localparam int SH = CAS_LAT + 3;
  localparam logic [7:0]    TRCD_LAST = 8'(TRCD - 1);
  localparam logic [7:0]    CAS_LAST  = 8'(CAS_LAT - 1);
  localparam logic [7:0]    TRP_LAST  = 8'(TRP - 1);
  localparam logic [7:0]    SLOT_LAST = 8'd3;
  localparam logic [BW-1:0] BURST_MAX = BW'(BURST_NUM);

  typedef enum logic [3:0] {
    S_IDLE, S_REQ, S_ACT, S_TRCD, S_READ, S_DRAIN, S_PRE, S_TRP, S_END
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [7:0]    r_cnt, w_cnt_nxt;
  logic [11:0]   r_row;
  logic [8:0]    r_col;
  logic [BW-1:0] r_burst;
  logic [SH-1:0] r_rd_sh;
  logic [15:0]   r_data;
  logic          r_vld;

  logic          w_job_done;
  logic          w_rd_issue;
  logic          w_req;
  logic          w_end;
  logic          w_dq_vld;
  logic [3:0]    w_cmd;
  logic [11:0]   w_addr;

  // Burst counter counts issued READs, so at a slot's last cycle it already
  // includes the burst in flight.
  assign w_job_done = (r_burst == BURST_MAX);

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 8'd1;
    w_cmd       = CMD_NOP;
    w_addr      = '0;
    w_req       = 1'b1;
    w_end       = 1'b0;
    w_rd_issue  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_req     = 1'b0;
        w_cnt_nxt = '0;
        if (bus.rd_trig) w_state_nxt = S_REQ;
      end
      S_REQ: begin
        w_cnt_nxt = '0;
        if (bus.rd_en) w_state_nxt = S_ACT;
      end
      S_ACT: begin
        w_cmd       = CMD_ACT;
        w_addr      = r_row;
        w_cnt_nxt   = '0;
        w_state_nxt = S_TRCD;
      end
      S_TRCD: begin
        if (r_cnt == TRCD_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_READ;
        end
      end
      S_READ: begin
        if (r_cnt == '0) begin
          w_cmd      = CMD_READ;
          w_addr     = {3'b000, r_col};
          w_rd_issue = 1'b1;
        end
        // Completion wins over a simultaneous refresh request.
        if (r_cnt == SLOT_LAST) begin
          w_cnt_nxt = '0;
          if (w_job_done || bus.ref_req) w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (r_cnt == CAS_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_PRE;
        end
      end
      S_PRE: begin
        w_cmd       = CMD_PRE;
        w_addr      = 12'h400;
        w_cnt_nxt   = '0;
        w_state_nxt = S_TRP;
      end
      S_TRP: begin
        if (r_cnt == TRP_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_END;
        end
      end
      S_END: begin
        w_end       = 1'b1;
        w_req       = ~w_job_done;
        w_cnt_nxt   = '0;
        w_state_nxt = w_job_done ? S_IDLE : S_REQ;
      end
      default: begin
        w_req       = 1'b0;
        w_cnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Row/column/burst progress survives a refresh yield; only a finished job clears it.
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      r_row   <= '0;
      r_col   <= '0;
      r_burst <= '0;
    end else if (r_state == S_END && w_job_done) begin
      r_row   <= r_row + 12'd1;
      r_col   <= '0;
      r_burst <= '0;
    end else if (w_rd_issue) begin
      r_col   <= r_col + 9'd4;
      r_burst <= r_burst + BW'(1);
    end
  end

  // r_rd_sh[k] marks a READ issued k+1 cycles ago; its burst is on the DQ pins
  // CAS_LAT..CAS_LAT+3 cycles after issue.
  assign w_dq_vld = |r_rd_sh[CAS_LAT+2:CAS_LAT-1];

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      r_rd_sh <= '0;
      r_data  <= '0;
      r_vld   <= 1'b0;
    end else begin
      r_rd_sh <= {r_rd_sh[SH-2:0], w_rd_issue};
      r_data  <= bus.sdram_dq;
      r_vld   <= w_dq_vld;
    end
  end

  assign bus.rd_cmd      = w_cmd;
  assign bus.rd_addr     = w_addr;
  assign bus.rd_bank     = '0;
  assign bus.rd_req      = w_req;
  assign bus.rd_end      = w_end;
  assign bus.rd_data     = r_data;
  assign bus.rd_data_vld = r_vld;
endmodule

// File: tb/tb_sdram_read.sv
// Directed bench for sdram_read: arbiter grants one cycle after rd_req and an
// SDRAM model returns {row[6:0], col} words CAS_LAT cycles after each READ.
module tb_sdram_read;
  localparam int CAS  = 3;
  localparam int LOGN = 4096;
  localparam logic [3:0] NOP = 4'b0111;
  localparam logic [3:0] ACT = 4'b0011;
  localparam logic [3:0] RD  = 4'b0101;
  localparam logic [3:0] PRE = 4'b0010;

  logic sclk    = 1'b0;
  logic s_rst_n = 1'b0;
  int   cyc     = 0;
  int   n_cmp   = 0;
  int   n_bad   = 0;

  sdram_read_if bus();

  sdram_read #(.CAS_LAT(CAS), .TRCD(2), .TRP(2), .BURST_NUM(4)) dut (
    .sclk   (sclk),
    .s_rst_n(s_rst_n),
    .bus    (bus)
  );

  always #5 sclk = ~sclk;
  always @(posedge sclk) cyc = cyc + 1;

  logic [3:0]  cmd_log  [0:LOGN-1];
  logic [11:0] addr_log [0:LOGN-1];
  logic [1:0]  bank_log [0:LOGN-1];
  logic        req_log  [0:LOGN-1];
  logic        end_log  [0:LOGN-1];
  logic        vld_log  [0:LOGN-1];
  logic [15:0] data_log [0:LOGN-1];
  logic [15:0] dq_sched [0:LOGN-1];
  logic [11:0] cur_row  = '0;
  logic        req_prev = 1'b0;

  // Mid-cycle: log outputs, model the SDRAM and the one-cycle-late arbiter grant.
  always @(negedge sclk) begin
    if (cyc < LOGN) begin
      cmd_log[cyc]  = bus.rd_cmd;
      addr_log[cyc] = bus.rd_addr;
      bank_log[cyc] = bus.rd_bank;
      req_log[cyc]  = bus.rd_req;
      end_log[cyc]  = bus.rd_end;
      vld_log[cyc]  = bus.rd_data_vld;
      data_log[cyc] = bus.rd_data;
    end
    if (bus.rd_cmd == ACT) cur_row = bus.rd_addr;
    if (bus.rd_cmd == RD)
      for (int k = 0; k < 4; k++)
        dq_sched[(cyc + CAS + k) % LOGN] = {cur_row[6:0], bus.rd_addr[8:0] + 9'(k)};
    bus.sdram_dq = dq_sched[cyc % LOGN];
    bus.rd_en    = req_prev;
    req_prev     = bus.rd_req;
  end

  int          n_act, n_rd, n_pre, n_end, n_vld, bank_bad;
  int          act_c [8];
  logic [11:0] act_r [8];
  int          rd_c  [16];
  logic [11:0] rd_a  [16];
  int          pre_c;
  logic [11:0] pre_a;
  logic [15:0] vld_d [32];
  int          vld_c [32];

  task automatic step();
    @(posedge sclk);
    #1;
  endtask

  task automatic pulse_trig();
    bus.rd_trig = 1'b1;
    step();
    bus.rd_trig = 1'b0;
  endtask

  task automatic wait_end(output int ec);
    ec = -1;
    for (int i = 0; i < 200 && ec < 0; i++) begin
      step();
      if (end_log[cyc-1] === 1'b1) ec = cyc - 1;
    end
    n_cmp++;
    if (ec < 0) begin
      n_bad++;
      $display("FAIL rd_end_timeout: got no pulse, want pulse within 200 cycles");
    end
  endtask

  task automatic scan(input int from, input int to);
    n_act = 0; n_rd = 0; n_pre = 0; n_end = 0; n_vld = 0; bank_bad = 0;
    pre_c = -1; pre_a = 'x;
    for (int i = 0; i < 16; i++) begin rd_c[i] = -1; rd_a[i] = 'x; end
    for (int i = 0; i < 8; i++) begin act_c[i] = -1; act_r[i] = 'x; end
    for (int c = from; c <= to; c++) begin
      if (cmd_log[c] == ACT && n_act < 8) begin act_c[n_act] = c; act_r[n_act] = addr_log[c]; n_act++; end
      if (cmd_log[c] == RD && n_rd < 16) begin rd_c[n_rd] = c; rd_a[n_rd] = addr_log[c]; n_rd++; end
      if (cmd_log[c] == PRE) begin if (n_pre == 0) begin pre_c = c; pre_a = addr_log[c]; end n_pre++; end
      if (end_log[c] === 1'b1) n_end++;
      if (vld_log[c] === 1'b1 && n_vld < 32) begin vld_c[n_vld] = c; vld_d[n_vld] = data_log[c]; n_vld++; end
      if (bank_log[c] !== 2'b00) bank_bad++;
    end
  endtask

  task automatic test_reset();
    bus.rd_trig = 1'b0; bus.ref_req = 1'b0; s_rst_n = 1'b0;
    repeat (3) step();
    n_cmp++;
    if ({bus.rd_cmd, bus.rd_addr, bus.rd_bank, bus.rd_req, bus.rd_end, bus.rd_data, bus.rd_data_vld}
        !== {NOP, 12'h000, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_values: got cmd=%b addr=%h bank=%b req=%b end=%b data=%h vld=%b, want 0111/0/0/0/0/0/0",
               bus.rd_cmd, bus.rd_addr, bus.rd_bank, bus.rd_req, bus.rd_end, bus.rd_data, bus.rd_data_vld);
    end
    s_rst_n = 1'b1;
    repeat (3) step();
  endtask

  task automatic test_basic_job();
    int t, e, a;
    t = cyc;
    pulse_trig();
    wait_end(e);
    if (e < 0) return;
    scan(t, e);
    a = act_c[0];
    n_cmp++; if (n_act !== 1) begin n_bad++; $display("FAIL basic_act_count: got %0d want 1", n_act); end
    n_cmp++; if (a !== t + 3) begin n_bad++; $display("FAIL basic_grant_to_act: got cycle %0d want %0d", a, t + 3); end
    n_cmp++; if (act_r[0] !== 12'd0) begin n_bad++; $display("FAIL basic_act_row: got %0d want 0", act_r[0]); end
    n_cmp++;
    if (cmd_log[a+1] !== NOP || cmd_log[a+2] !== NOP) begin
      n_bad++; $display("FAIL basic_trcd_nops: got %b %b want 0111 0111", cmd_log[a+1], cmd_log[a+2]);
    end
    n_cmp++; if (n_rd !== 4) begin n_bad++; $display("FAIL basic_read_count: got %0d want 4", n_rd); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (rd_c[i] !== a + 3 + 4*i || rd_a[i] !== 12'(4*i)) begin
        n_bad++;
        $display("FAIL basic_read%0d: got cycle %0d col %0d want cycle %0d col %0d", i, rd_c[i] - a, rd_a[i], 3 + 4*i, 4*i);
      end
    end
    n_cmp++;
    if (n_vld !== 16 || vld_c[0] !== a + 7 || vld_c[15] !== a + 22) begin
      n_bad++;
      $display("FAIL basic_vld_window: got %0d cycles from ACT+%0d want 16 from ACT+7", n_vld, vld_c[0] - a);
    end
    for (int i = 0; i < 16 && i < n_vld; i++) begin
      n_cmp++;
      if (vld_d[i] !== 16'(i)) begin n_bad++; $display("FAIL basic_data%0d: got %h want %h", i, vld_d[i], 16'(i)); end
    end
    n_cmp++;
    if (n_pre !== 1 || pre_c !== a + 22 || pre_a !== 12'h400) begin
      n_bad++;
      $display("FAIL basic_precharge: got %0d PRE at ACT+%0d addr %h want 1 at ACT+22 addr 400", n_pre, pre_c - a, pre_a);
    end
    n_cmp++; if (e !== a + 25) begin n_bad++; $display("FAIL basic_job_length: got %0d want 25", e - a); end
    n_cmp++;
    if (req_log[e] !== 1'b0 || req_log[e-1] !== 1'b1) begin
      n_bad++; $display("FAIL basic_req_release: got req %b,%b at end-1,end want 1,0", req_log[e-1], req_log[e]);
    end
    n_cmp++; if (bank_bad !== 0) begin n_bad++; $display("FAIL basic_bank: got %0d nonzero cycles want 0", bank_bad); end
    repeat (3) step();
  endtask

  task automatic test_second_trig();
    int t, e;
    t = cyc;
    pulse_trig();
    wait_end(e);
    if (e < 0) return;
    scan(t, e);
    n_cmp++;
    if (n_act !== 1 || act_r[0] !== 12'd1) begin
      n_bad++; $display("FAIL second_job_row: got %0d ACTs row %0d want 1 ACT row 1", n_act, act_r[0]);
    end
    n_cmp++;
    if (n_rd !== 4 || rd_a[0] !== 12'd0 || e - act_c[0] !== 25) begin
      n_bad++; $display("FAIL second_job_shape: got %0d READs col0 %0d len %0d want 4/0/25", n_rd, rd_a[0], e - act_c[0]);
    end
    repeat (3) step();
  endtask

  task automatic test_trig_ignored();
    int t, e;
    t = cyc;
    pulse_trig();
    while (cyc < t + 8) step();
    pulse_trig();
    wait_end(e);
    if (e < 0) return;
    repeat (40) step();
    scan(t, cyc - 1);
    n_cmp++;
    if (n_act !== 1 || n_end !== 1 || act_r[0] !== 12'd2) begin
      n_bad++; $display("FAIL trig_ignored: got %0d ACTs %0d ends row %0d want 1/1/2", n_act, n_end, act_r[0]);
    end
  endtask

  task automatic test_row_wrap();
    int t, e;
    force dut.r_row = 12'd4095;
    step();
    release dut.r_row;
    step();
    t = cyc;
    pulse_trig();
    wait_end(e);
    if (e < 0) return;
    scan(t, e);
    n_cmp++; if (act_r[0] !== 12'hFFF) begin n_bad++; $display("FAIL wrap_row_4095: got %h want fff", act_r[0]); end
    repeat (3) step();
    t = cyc;
    pulse_trig();
    wait_end(e);
    if (e < 0) return;
    scan(t, e);
    n_cmp++; if (act_r[0] !== 12'h000) begin n_bad++; $display("FAIL wrap_row_0: got %h want 000", act_r[0]); end
    repeat (3) step();
  endtask

  task automatic test_ref_interrupt();
    int t, a, e1, e2, a2;
    s_rst_n = 1'b0;
    repeat (2) step();
    s_rst_n = 1'b1;
    repeat (2) step();
    t = cyc;
    a = t + 3;
    pulse_trig();
    while (cyc < a + 8) step();
    bus.ref_req = 1'b1;
    while (cyc < a + 11) step();
    bus.ref_req = 1'b0;
    wait_end(e1);
    if (e1 < 0) return;
    scan(t, e1);
    n_cmp++;
    if (n_rd !== 2 || act_c[0] !== a || act_r[0] !== 12'd0) begin
      n_bad++; $display("FAIL ref_first_part: got %0d READs ACT@%0d row %0d want 2 READs ACT@%0d row 0", n_rd, act_c[0], act_r[0], a);
    end
    n_cmp++;
    if (pre_c !== a + 14 || pre_a !== 12'h400 || e1 !== a + 17) begin
      n_bad++; $display("FAIL ref_yield_timing: got PRE ACT+%0d addr %h end ACT+%0d want 14/400/17", pre_c - a, pre_a, e1 - a);
    end
    n_cmp++; if (req_log[e1] !== 1'b1) begin n_bad++; $display("FAIL ref_req_held: got rd_req %b at end want 1", req_log[e1]); end
    wait_end(e2);
    if (e2 < 0) return;
    scan(e1 + 1, e2);
    a2 = act_c[0];
    n_cmp++;
    if (n_act !== 1 || act_r[0] !== 12'd0 || n_rd !== 2) begin
      n_bad++; $display("FAIL ref_resume_act: got %0d ACTs row %0d %0d READs want 1/0/2", n_act, act_r[0], n_rd);
    end
    n_cmp++;
    if (rd_a[0] !== 12'd8 || rd_a[1] !== 12'd12 || rd_c[0] !== a2 + 3 || rd_c[1] !== a2 + 7) begin
      n_bad++; $display("FAIL ref_resume_cols: got cols %0d,%0d want 8,12", rd_a[0], rd_a[1]);
    end
    n_cmp++;
    if (e2 !== a2 + 17 || req_log[e2] !== 1'b0) begin
      n_bad++; $display("FAIL ref_resume_end: got len %0d req %b want 17 0", e2 - a2, req_log[e2]);
    end
    scan(t, e2);
    n_cmp++; if (n_vld !== 16) begin n_bad++; $display("FAIL ref_vld_count: got %0d want 16", n_vld); end
    for (int i = 0; i < 16 && i < n_vld; i++) begin
      n_cmp++;
      if (vld_d[i] !== 16'(i)) begin n_bad++; $display("FAIL ref_data%0d: got %h want %h", i, vld_d[i], 16'(i)); end
    end
    repeat (3) step();
  endtask

  task automatic test_async_reset();
    int t, a;
    t = cyc;
    a = t + 3;
    pulse_trig();
    while (cyc < a + 11) step();
    #2;
    n_cmp++;
    if (bus.rd_cmd !== RD || bus.rd_addr !== 12'd8 || bus.rd_data_vld !== 1'b1) begin
      n_bad++; $display("FAIL pre_reset_burst: got cmd %b addr %0d vld %b want 0101 8 1", bus.rd_cmd, bus.rd_addr, bus.rd_data_vld);
    end
    s_rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.rd_cmd, bus.rd_addr, bus.rd_bank, bus.rd_req, bus.rd_end, bus.rd_data, bus.rd_data_vld}
        !== {NOP, 12'h000, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b0}) begin
      n_bad++;
      $display("FAIL async_reset: got cmd=%b addr=%h bank=%b req=%b end=%b data=%h vld=%b, want 0111/0/0/0/0/0/0",
               bus.rd_cmd, bus.rd_addr, bus.rd_bank, bus.rd_req, bus.rd_end, bus.rd_data, bus.rd_data_vld);
    end
    repeat (2) step();
    s_rst_n = 1'b1;
    repeat (3) step();
    n_cmp++;
    if (bus.rd_cmd !== NOP || bus.rd_req !== 1'b0) begin
      n_bad++; $display("FAIL post_reset_idle: got cmd %b req %b want 0111 0", bus.rd_cmd, bus.rd_req);
    end
  endtask

  initial begin
    test_reset();
    test_basic_job();
    test_second_trig();
    test_trig_ignored();
    test_row_wrap();
    test_ref_interrupt();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
